// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: round-robin sharing of one simple system-bus slave port
// between NM single-pulse masters, with a per-transaction timeout that
// produces an error acknowledge so no master can lock up.
module sys_bus_arbiter #(
  parameter int unsigned NM      = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned SW      = DW >> 3,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic [NM*AW-1:0] m_addr_i,
  input  logic [NM*DW-1:0] m_wdata_i,
  input  logic [NM*SW-1:0] m_sel_i,
  input  logic [NM-1:0]    m_wen_i,
  input  logic [NM-1:0]    m_ren_i,
  output logic [NM-1:0]    m_busy_o,
  output logic [NM-1:0]    m_ack_o,
  output logic             m_err_o,
  output logic [DW-1:0]    m_rdata_o,
  output logic [NM-1:0]    m_ovf_o,
  output logic [AW-1:0]    s_addr_o,
  output logic [DW-1:0]    s_wdata_o,
  output logic [SW-1:0]    s_sel_o,
  output logic             s_wen_o,
  output logic             s_ren_o,
  input  logic [DW-1:0]    s_rdata_i,
  input  logic             s_err_i,
  input  logic             s_ack_i
);

  localparam int unsigned LW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [LW-1:0]          last_q, last_d;
  logic [LW-1:0]          owner_q, owner_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NM-1:0]          busy_q, busy_d;
  logic [NM-1:0]          ovf_q, ovf_d;
  logic [NM-1:0]          req_we_q, req_we_d;
  logic [NM-1:0][AW-1:0]  req_addr_q, req_addr_d;
  logic [NM-1:0][DW-1:0]  req_wdata_q, req_wdata_d;
  logic [NM-1:0][SW-1:0]  req_sel_q, req_sel_d;
  logic [AW-1:0]          s_addr_q, s_addr_d;
  logic [DW-1:0]          s_wdata_q, s_wdata_d;
  logic [SW-1:0]          s_sel_q, s_sel_d;
  logic                   s_wen_q, s_wen_d;
  logic                   s_ren_q, s_ren_d;
  logic [NM-1:0]          m_ack_q, m_ack_d;
  logic                   m_err_q, m_err_d;
  logic [DW-1:0]          m_rdata_q, m_rdata_d;

  logic                   gnt_found;
  logic [LW-1:0]          gnt_idx;
  logic [LW-1:0]          cand;

  // Round-robin search: first pending master strictly after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_q;
    cand      = last_q;
    for (int unsigned k = 1; k <= NM; k++) begin
      cand = LW'((32'(last_q) + k) % NM);
      if (!gnt_found && busy_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Request capture, overflow tracking and the IDLE/WAIT transaction FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_sel_d   = req_sel_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_sel_d     = s_sel_q;
    s_wen_d     = 1'b0;
    s_ren_d     = 1'b0;
    m_ack_d     = '0;
    m_err_d     = m_err_q;
    m_rdata_d   = m_rdata_q;

    // busy_q is already low in the cycle m_ack_o fires, so a re-request
    // arriving together with its own ack is accepted here.
    for (int i = 0; i < int'(NM); i++) begin
      if (m_wen_i[i] || m_ren_i[i]) begin
        if (busy_q[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          busy_d[i]      = 1'b1;
          req_we_d[i]    = m_wen_i[i];
          req_addr_d[i]  = m_addr_i[i*AW +: AW];
          req_wdata_d[i] = m_wdata_i[i*DW +: DW];
          req_sel_d[i]   = m_sel_i[i*SW +: SW];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          last_d    = gnt_idx;
          owner_d   = gnt_idx;
          s_addr_d  = req_addr_q[gnt_idx];
          s_wdata_d = req_wdata_q[gnt_idx];
          s_sel_d   = req_sel_q[gnt_idx];
          s_wen_d   = req_we_q[gnt_idx];
          s_ren_d   = !req_we_q[gnt_idx];
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (s_ack_i) begin
          m_ack_d[owner_q] = 1'b1;
          m_err_d          = s_err_i;
          if (!req_we_q[owner_q]) begin
            m_rdata_d = s_rdata_i;
          end
          busy_d[owner_q]  = 1'b0;
          state_d          = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          m_ack_d[owner_q] = 1'b1;
          m_err_d          = 1'b1;
          busy_d[owner_q]  = 1'b0;
          state_d          = S_IDLE;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q     <= S_IDLE;
      last_q      <= LW'(NM - 1);
      owner_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= '0;
      ovf_q       <= '0;
      req_we_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_sel_q   <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_sel_q     <= '0;
      s_wen_q     <= 1'b0;
      s_ren_q     <= 1'b0;
      m_ack_q     <= '0;
      m_err_q     <= 1'b0;
      m_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_sel_q   <= req_sel_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_sel_q     <= s_sel_d;
      s_wen_q     <= s_wen_d;
      s_ren_q     <= s_ren_d;
      m_ack_q     <= m_ack_d;
      m_err_q     <= m_err_d;
      m_rdata_q   <= m_rdata_d;
    end
  end

  assign m_busy_o  = busy_q;
  assign m_ack_o   = m_ack_q;
  assign m_err_o   = m_err_q;
  assign m_rdata_o = m_rdata_q;
  assign m_ovf_o   = ovf_q;
  assign s_addr_o  = s_addr_q;
  assign s_wdata_o = s_wdata_q;
  assign s_sel_o   = s_sel_q;
  assign s_wen_o   = s_wen_q;
  assign s_ren_o   = s_ren_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed bench for sys_bus_arbiter (NM=2, TIMEOUT=32).
module tb_sys_bus_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW >> 3;
  localparam int unsigned TO = 32;

  logic             clk;
  logic             rst;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_sel;
  logic [NM-1:0]    m_wen;
  logic [NM-1:0]    m_ren;
  logic [NM-1:0]    m_busy;
  logic [NM-1:0]    m_ack;
  logic             m_err;
  logic [DW-1:0]    m_rdata;
  logic [NM-1:0]    m_ovf;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [SW-1:0]    s_sel;
  logic             s_wen;
  logic             s_ren;
  logic [DW-1:0]    s_rdata;
  logic             s_err;
  logic             s_ack;

  int errors = 0;
  int checks = 0;

  sys_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_sel_i   (m_sel),
    .m_wen_i   (m_wen),
    .m_ren_i   (m_ren),
    .m_busy_o  (m_busy),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_rdata_o (m_rdata),
    .m_ovf_o   (m_ovf),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_sel_o   (s_sel),
    .s_wen_o   (s_wen),
    .s_ren_o   (s_ren),
    .s_rdata_i (s_rdata),
    .s_err_i   (s_err),
    .s_ack_i   (s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    m_wen   = '0;
    m_ren   = '0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_rdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] d);
    m_addr[m*AW +: AW]  = a;
    m_wdata[m*DW +: DW] = d;
    m_sel[m*SW +: SW]   = 4'hF;
  endtask

  // Bounded wait for a slave strobe, current cycle included.
  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    while (!(s_wen || s_ren) && n < 60) begin
      step();
      n++;
    end
    check(tag, 64'(s_wen || s_ren), 64'd1);
  endtask

  initial begin
    int bad;
    m_addr  = '0;
    m_wdata = '0;
    m_sel   = '0;
    do_reset();

    // Reset state
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_ack", 64'(m_ack), 64'd0);
    check("rst_strobes", 64'({s_wen, s_ren}), 64'd0);
    check("rst_ovf", 64'(m_ovf), 64'd0);
    check("rst_saddr", 64'(s_addr), 64'd0);

    // Single read by master 0, slave acks 3 cycles after strobe
    set_req(0, 32'h4000_0010, 32'h0);
    m_ren = 2'b01;
    step();
    m_ren = 2'b00;
    check("rd_busy_t1", 64'(m_busy), 64'd1);
    check("rd_noearly_strobe", 64'(s_ren), 64'd0);
    step();
    check("rd_sren_t2", 64'(s_ren), 64'd1);
    check("rd_saddr", 64'(s_addr), 64'h4000_0010);
    step();
    check("rd_sren_1cyc", 64'(s_ren), 64'd0);
    step();
    step();
    check("rd_noack_yet", 64'(m_ack), 64'd0);
    check("rd_saddr_stable", 64'(s_addr), 64'h4000_0010);
    s_ack   = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    step();
    s_ack   = 1'b0;
    s_rdata = '0;
    check("rd_ack", 64'(m_ack), 64'd1);
    check("rd_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    check("rd_err", 64'(m_err), 64'd0);
    check("rd_busy_clr", 64'(m_busy), 64'd0);
    step();
    check("rd_ack_1cyc", 64'(m_ack), 64'd0);

    // Timeout: master 1 reads, slave never acks
    set_req(1, 32'h0000_0300, 32'h0);
    m_ren = 2'b10;
    step();
    m_ren = 2'b00;
    wait_strobe("to_strobe");
    check("to_saddr", 64'(s_addr), 64'h300);
    bad = 0;
    for (int j = 1; j < int'(TO); j++) begin
      step();
      if (m_ack != 2'b00) bad++;
    end
    check("to_no_early_ack", 64'(bad), 64'd0);
    step();
    check("to_ack", 64'(m_ack), 64'd2);
    check("to_err", 64'(m_err), 64'd1);
    check("to_rdata_hold", 64'(m_rdata), 64'hDEAD_BEEF);
    check("to_busy_clr", 64'(m_busy), 64'd0);
    repeat (8) step();
    s_ack   = 1'b1;
    s_rdata = 32'h1234_5678;
    step();
    s_ack = 1'b0;
    check("late_ack_ignored", 64'(m_ack), 64'd0);
    step();
    check("late_ack_ignored2", 64'(m_ack), 64'd0);
    check("late_rdata_hold", 64'(m_rdata), 64'hDEAD_BEEF);

    // Simultaneous writes after reset: master 0 first, then master 1
    do_reset();
    set_req(0, 32'h0000_0100, 32'h1111_1111);
    set_req(1, 32'h0000_0200, 32'h2222_2222);
    m_wen = 2'b11;
    step();
    m_wen = 2'b00;
    check("sim_busy", 64'(m_busy), 64'd3);
    step();
    check("sim_swen0", 64'(s_wen), 64'd1);
    check("sim_addr0", 64'(s_addr), 64'h100);
    check("sim_wdata0", 64'(s_wdata), 64'h1111_1111);
    step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    check("sim_ack0", 64'(m_ack), 64'd1);
    check("sim_gap", 64'(s_wen), 64'd0);
    check("sim_addr_hold", 64'(s_addr), 64'h100);
    step();
    check("sim_swen1", 64'(s_wen), 64'd1);
    check("sim_addr1", 64'(s_addr), 64'h200);
    check("sim_wdata1", 64'(s_wdata), 64'h2222_2222);
    step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    check("sim_ack1", 64'(m_ack), 64'd2);
    check("sim_busy_clr", 64'(m_busy), 64'd0);

    // Round-robin fairness: each master re-requests at its own ack
    do_reset();
    set_req(0, 32'h0000_1000, 32'hA0A0_A0A0);
    set_req(1, 32'h0000_2000, 32'hB1B1_B1B1);
    m_wen = 2'b11;
    step();
    m_wen = 2'b00;
    for (int n = 0; n < 6; n++) begin
      wait_strobe("rr_strobe");
      check("rr_order", 64'(s_addr), (n % 2 == 0) ? 64'h1000 : 64'h2000);
      step();
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      check("rr_ack", 64'(m_ack), (n % 2 == 0) ? 64'd1 : 64'd2);
      m_wen = m_ack;
      step();
      m_wen = 2'b00;
    end
    check("rr_ovf", 64'(m_ovf), 64'd0);

    // Overflow: master 1 pulses again while busy
    do_reset();
    set_req(1, 32'h0000_0400, 32'h0000_AAAA);
    m_wen = 2'b10;
    step();
    set_req(1, 32'h0000_0500, 32'h0000_BBBB);
    step();
    m_wen = 2'b00;
    check("ovf_set", 64'(m_ovf), 64'd2);
    check("ovf_strobe", 64'(s_wen), 64'd1);
    check("ovf_first_addr", 64'(s_addr), 64'h400);
    check("ovf_first_wdata", 64'(s_wdata), 64'h0000_AAAA);
    step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    check("ovf_ack", 64'(m_ack), 64'd2);
    check("ovf_busy_clr", 64'(m_busy), 64'd0);
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (s_wen || s_ren) bad++;
    end
    check("ovf_dropped", 64'(bad), 64'd0);
    check("ovf_sticky", 64'(m_ovf), 64'd2);

    // Reset mid-transaction
    set_req(0, 32'h0000_0600, 32'h0);
    m_ren = 2'b01;
    step();
    m_ren = 2'b00;
    wait_strobe("mid_strobe");
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_busy", 64'(m_busy), 64'd0);
    check("mid_ovf", 64'(m_ovf), 64'd0);
    check("mid_saddr", 64'(s_addr), 64'd0);
    check("mid_strobes", 64'({s_wen, s_ren}), 64'd0);
    check("mid_ack_err", 64'({m_ack, m_err}), 64'd0);
    step();
    rst   = 1'b0;
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    check("mid_no_ack", 64'(m_ack), 64'd0);
    check("mid_idle_nostrobe", 64'({s_wen, s_ren}), 64'd0);
    set_req(1, 32'h0000_0700, 32'h0);
    m_ren = 2'b10;
    step();
    m_ren = 2'b00;
    check("post_busy", 64'(m_busy), 64'd2);
    step();
    check("post_sren", 64'(s_ren), 64'd1);
    check("post_saddr", 64'(s_addr), 64'h700);
    s_ack   = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    step();
    s_ack   = 1'b0;
    check("post_ack", 64'(m_ack), 64'd2);
    check("post_rdata", 64'(m_rdata), 64'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
